// File: rtl/bka_pkg.sv
// bka_pkg: shared pair type, black-cell combine and limits for the pipelined Brent-Kung adder
package bka_pkg;
  localparam int BKA_LATENCY = 3;
  localparam int BKA_MAX_WIDTH = 64;
  typedef struct packed {
    logic g;
    logic p;
  } pg_t;
  function automatic pg_t bka_combine(input pg_t hi, input pg_t lo);
    return '{g: hi.g | (hi.p & lo.g), p: hi.p & lo.p};
  endfunction
endpackage

// File: rtl/bka_pg_cell.sv
// bka_pg_cell: combinational Brent-Kung black cell merging a high and a low (G,P) span
module bka_pg_cell
  import bka_pkg::*;
(
  input  pg_t i_hi,
  input  pg_t i_lo,
  output pg_t o_pg
);
  assign o_pg = bka_combine(i_hi, i_lo);
endmodule

// File: rtl/bka_pipe_adder.sv
// bka_pipe_adder: 3-stage pipelined Brent-Kung add/sub with carry, overflow and valid/ready.
// Define BKA_SAT_EN to add the sat input that clamps overflowing results to the signed limit.
module bka_pipe_adder
  import bka_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef BKA_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  if (WIDTH < 4 || WIDTH > BKA_MAX_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("bka_pipe_adder: WIDTH must be a power of two in 4..64");
  end
  logic             w_adv, w_ovf, w_unused;
  logic             r1_v, r2_v, r_ov, r1_cin, r2_cin, r_cout, r_ovf;
  logic [WIDTH-1:0] w_bb, w_c, w_sum, w_s;
  logic [WIDTH-1:0] r1_p, r1_g, r2_g, r2_p, r2_po, r_s;
  assign w_adv = !r_ov || out_ready;
  assign in_ready = w_adv && !rst;
  assign w_bb = sub ? ~b : b;
  genvar k, i;
  // Up-sweep: level k merges spans ending at indices 2^k-1 apart; cin enters as g_-1 at bit 0
  for (k = 0; k <= LOG2W; k++) begin : g_up
    logic [WIDTH-1:0] w_g, w_p;
    if (k == 0) begin : g_l0
      assign w_g = {r1_g[WIDTH-1:1], r1_g[0] | (r1_p[0] & r1_cin)};
      assign w_p = r1_p;
    end else begin : g_ln
      for (i = 0; i < WIDTH; i++) begin : g_b
        if ((i + 1) % (1 << k) == 0) begin : g_cell
          pg_t w_hi, w_lo, w_o;
          assign w_hi = {g_up[k-1].w_g[i], g_up[k-1].w_p[i]};
          assign w_lo = {g_up[k-1].w_g[i-(1<<(k-1))], g_up[k-1].w_p[i-(1<<(k-1))]};
          bka_pg_cell u_cell (.i_hi(w_hi), .i_lo(w_lo), .o_pg(w_o));
          assign w_g[i] = w_o.g;
          assign w_p[i] = w_o.p;
        end else begin : g_pass
          assign w_g[i] = g_up[k-1].w_g[i];
          assign w_p[i] = g_up[k-1].w_p[i];
        end
      end
    end
  end
  // Down-sweep: each level fills the midpoints between already-complete prefixes
  for (k = 0; k < LOG2W; k++) begin : g_dn
    logic [WIDTH-1:0] w_g, w_p;
    if (k == 0) begin : g_l0
      assign w_g = r2_g;
      assign w_p = r2_p;
    end else begin : g_ln
      localparam int STEP = 1 << (LOG2W - k);
      localparam int HALF = STEP / 2;
      for (i = 0; i < WIDTH; i++) begin : g_b
        if (i >= STEP && (i + 1) % STEP == HALF) begin : g_cell
          pg_t w_hi, w_lo, w_o;
          assign w_hi = {g_dn[k-1].w_g[i], g_dn[k-1].w_p[i]};
          assign w_lo = {g_dn[k-1].w_g[i-HALF], g_dn[k-1].w_p[i-HALF]};
          bka_pg_cell u_cell (.i_hi(w_hi), .i_lo(w_lo), .o_pg(w_o));
          assign w_g[i] = w_o.g;
          assign w_p[i] = w_o.p;
        end else begin : g_pass
          assign w_g[i] = g_dn[k-1].w_g[i];
          assign w_p[i] = g_dn[k-1].w_p[i];
        end
      end
    end
  end
  assign w_c = g_dn[LOG2W-1].w_g;
  assign w_unused = ^g_dn[LOG2W-1].w_p;
  assign w_sum = r2_po ^ {w_c[WIDTH-2:0], r2_cin};
  assign w_ovf = w_c[WIDTH-1] ^ w_c[WIDTH-2];
`ifdef BKA_SAT_EN
  logic r1_sat, r2_sat, r1_am, r2_am;
  always_ff @(posedge clk)
    if (w_adv) begin
      r1_sat <= sat;
      r1_am  <= a[WIDTH-1];
      r2_sat <= r1_sat;
      r2_am  <= r1_am;
    end
  assign w_s = (r2_sat && w_ovf) ? {r2_am, {(WIDTH-1){!r2_am}}} : w_sum;
`else
  assign w_s = w_sum;
`endif
  always_ff @(posedge clk)
    if (w_adv) begin
      r1_p   <= a ^ w_bb;
      r1_g   <= a & w_bb;
      r1_cin <= cin;
      r2_g   <= g_up[LOG2W].w_g;
      r2_p   <= g_up[LOG2W].w_p;
      r2_po  <= r1_p;
      r2_cin <= r1_cin;
    end
  always_ff @(posedge clk)
    if (rst) begin
      r1_v   <= 1'b0;
      r2_v   <= 1'b0;
      r_ov   <= 1'b0;
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_adv) begin
      r1_v   <= in_valid;
      r2_v   <= r1_v;
      r_ov   <= r2_v;
      r_s    <= w_s;
      r_cout <= w_c[WIDTH-1];
      r_ovf  <= w_ovf;
    end
  assign out_valid = r_ov;
  assign s = r_s;
  assign cout = r_cout;
  assign ovf = r_ovf;
endmodule

// File: tb/tb_bka_pipe_adder.sv
// tb_bka_pipe_adder: directed vectors with hand-computed {s,cout,ovf}, in-order scoreboard
module tb_bka_pipe_adder;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0, sub = 1'b0;
  logic in_ready, out_valid, cout, ovf;
  logic [W-1:0] a = '0, b = '0, s;
  logic [17:0] cur_e = '0, mon_e;
  logic [17:0] exp_q[$];
  int n_chk = 0, n_fail = 0, n_acc = 0, n_ret = 0;
`ifdef BKA_SAT_EN
  logic sat = 1'b0;
`endif
  logic [15:0] va [10] = '{16'h0001, 16'h8000, 16'h00FF, 16'h0010, 16'h8000,
                           16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 16'h4000};
  logic [15:0] vb [10] = '{16'h0001, 16'h8000, 16'h0001, 16'h0001, 16'h0001,
                           16'h5555, 16'h5555, 16'h0000, 16'h0000, 16'h4000};
  logic        vc [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        vs [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [17:0] ve [10] = '{{16'h0002, 2'b00}, {16'h0000, 2'b11}, {16'h0101, 2'b00},
                           {16'h000F, 2'b10}, {16'h7FFF, 2'b11}, {16'hFFFF, 2'b00},
                           {16'h0000, 2'b10}, {16'hFFFF, 2'b00}, {16'h0000, 2'b10},
                           {16'h8000, 2'b01}};

  bka_pipe_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef BKA_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                      input logic ts, input logic [17:0] e);
    int t;
    a = ta; b = tb; cin = tc; sub = ts; cur_e = e; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("accept_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'(1), 32'(0));
        else begin
          mon_e = exp_q.pop_front();
          chk("s", 32'(s), 32'(mon_e[17:2]));
          chk("cout", 32'(cout), 32'(mon_e[1]));
          chk("ovf", 32'(ovf), 32'(mon_e[0]));
          n_ret++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_e);
        n_acc++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    in_valid = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_s", 32'(s), 32'(0));
      chk("rst_cout", 32'(cout), 32'(0));
      chk("rst_ovf", 32'(ovf), 32'(0));
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #0 chk("post_rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; cur_e = {16'h5555, 2'b00};
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", 32'(n), 32'(3));
    @(posedge clk);
    #1 chk("valid_drop", 32'(out_valid), 32'(0));
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 2'b10});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 2'b01});
    send(16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFE, 2'b00});
    repeat (5) @(posedge clk);
    #1;
    fork
      begin
        for (int j = 0; j < 10; j++) send(va[j], vb[j], vc[j], vs[j], ve[j]);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'(0));
          chk("stall_out_valid", 32'(out_valid), 32'(1));
          chk("stall_hold", 32'({s, cout, ovf}), 32'(ve[1]));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    chk("retired_count", 32'(n_ret), 32'(14));
    chk("accepted_count", 32'(n_acc), 32'(14));
    send(16'h1111, 16'h2222, 1'b0, 1'b0, {16'h3333, 2'b00});
    send(16'h3333, 16'h4444, 1'b0, 1'b0, {16'h7777, 2'b00});
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'(0));
    chk("flush_in_ready", 32'(in_ready), 32'(0));
    rst = 1'b0;
    #0 chk("flush_in_ready_after", 32'(in_ready), 32'(1));
    repeat (6) @(posedge clk);
    #1 chk("flush_none_retired", 32'(n_ret), 32'(14));
    send(16'h0003, 16'h0004, 1'b0, 1'b0, {16'h0007, 2'b00});
    repeat (5) @(posedge clk);
    #1 chk("post_flush_retired", 32'(n_ret), 32'(15));
`ifdef BKA_SAT_EN
    sat = 1'b1;
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h7FFF, 2'b01});
    send(16'h8000, 16'h8000, 1'b0, 1'b0, {16'h8000, 2'b11});
    sat = 1'b0;
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 2'b01});
    repeat (5) @(posedge clk);
    #1 chk("sat_retired", 32'(n_ret), 32'(18));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
